// File: rtl/floo_latency_model_pkg.sv
// Shared types and constants for the floo_latency_model slice.
//   FLOO_LATENCY_MODEL_ENTRY_T(name, dw, lw) : builds a packed {data, cnt} entry type
//   HBMLatencyDefault / MaxTxnsDefault       : default endpoint latency and depth
//   lat_load()                               : counter load value for a requested latency
`ifndef FLOO_LATENCY_MODEL_ENTRY_T
`define FLOO_LATENCY_MODEL_ENTRY_T(name, dw, lw) \
  typedef struct packed { \
    logic [(dw)-1:0] data; \
    logic [(lw)-1:0] cnt; \
  } name;
`endif

package floo_latency_model_pkg;

  localparam int unsigned HBMLatencyDefault = 100;
  localparam int unsigned MaxTxnsDefault    = 32;

  // Latency is clamped to max_lat, 0 behaves as 1, and the counter holds
  // (latency - 1) so the beat becomes visible exactly latency cycles later.
  function automatic int unsigned lat_load(input int unsigned lat,
                                           input int unsigned max_lat);
    int unsigned l;
    l = (lat > max_lat) ? max_lat : lat;
    return (l == 0) ? 0 : l - 1;
  endfunction

endpackage

// File: rtl/floo_latency_cnt.sv
// Single-entry latency down-counter.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   load_i       : load load_val_i (takes priority over counting)
//   load_val_i   : value loaded on accept
//   en_i         : entry holds a beat; counts down while nonzero
//   zero_o       : counter has reached zero (beat ripe)
module floo_latency_cnt #(
  parameter int unsigned LatWidth = 9
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                load_i,
  input  logic [LatWidth-1:0] load_val_i,
  input  logic                en_i,
  output logic                zero_o
);

  logic [LatWidth-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - LatWidth'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/floo_latency_model.sv
// In-order valid/ready latency-insertion buffer for NoC endpoint models.
// Each accepted beat is held for a runtime-programmable latency (clamped to
// MaxLatency, 0 treated as 1) and released strictly in FIFO order.
//   clk_i, rst_i        : clock, asynchronous active-high reset
//   latency_i           : latency for the beat accepted this cycle
//   valid_i/ready_o     : input handshake, data_i payload
//   valid_o/ready_i     : output handshake, data_o head payload (0 when not valid)
//   num_pending_o       : beats stored, busy_o = num_pending_o != 0
// Optional (macro FLOO_LATENCY_MODEL_STATS_EN):
//   stat_beats_o        : accepted beats, wrapping
//   stat_max_pending_o  : high-water mark of num_pending_o
//   stat_stall_cycles_o : cycles with valid_o && !ready_i, saturating
module floo_latency_model
  import floo_latency_model_pkg::*;
#(
  parameter int unsigned DataWidth  = 64,
  parameter int unsigned MaxLatency = 256,
  parameter int unsigned MaxTxns    = MaxTxnsDefault,
  parameter int unsigned LatWidth   = $clog2(MaxLatency + 1),
  parameter int unsigned CntWidth   = $clog2(MaxTxns + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [LatWidth-1:0]  latency_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [DataWidth-1:0] data_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [DataWidth-1:0] data_o,
  output logic [CntWidth-1:0]  num_pending_o,
  output logic                 busy_o
`ifdef FLOO_LATENCY_MODEL_STATS_EN
  ,
  output logic [31:0]          stat_beats_o,
  output logic [CntWidth-1:0]  stat_max_pending_o,
  output logic [31:0]          stat_stall_cycles_o
`endif
);

  localparam int unsigned PtrWidth = (MaxTxns > 1) ? $clog2(MaxTxns) : 1;

  `FLOO_LATENCY_MODEL_ENTRY_T(entry_t, DataWidth, LatWidth)

  entry_t               wr_entry;
  logic [PtrWidth-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntWidth-1:0]  count_q, count_next;
  logic [MaxTxns-1:0]   entry_valid_q;
  logic [MaxTxns-1:0]   cnt_zero;
  logic [DataWidth-1:0] data_q [MaxTxns];
  logic                 push, pop;

  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
    return (p == PtrWidth'(MaxTxns - 1)) ? '0 : p + PtrWidth'(1);
  endfunction

  always_comb begin
    wr_entry.data = data_i;
    wr_entry.cnt  = LatWidth'(lat_load(32'(latency_i), MaxLatency));
  end

  // Readiness depends only on stored occupancy: a pop in the same cycle
  // does not free a slot for a simultaneous push.
  assign ready_o = (count_q != CntWidth'(MaxTxns));
  assign valid_o = entry_valid_q[rd_ptr_q] && cnt_zero[rd_ptr_q];
  assign data_o  = valid_o ? data_q[rd_ptr_q] : '0;
  assign push    = valid_i && ready_o;
  assign pop     = valid_o && ready_i;

  assign num_pending_o = count_q;
  assign busy_o        = (count_q != '0);

  always_comb begin
    count_next = count_q;
    if (push && !pop)      count_next = count_q + CntWidth'(1);
    else if (!push && pop) count_next = count_q - CntWidth'(1);
  end

  for (genvar g = 0; g < MaxTxns; g++) begin : gen_cnt
    floo_latency_cnt #(
      .LatWidth (LatWidth)
    ) u_cnt (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .load_i     (push && (wr_ptr_q == PtrWidth'(g))),
      .load_val_i (wr_entry.cnt),
      .en_i       (entry_valid_q[g]),
      .zero_o     (cnt_zero[g])
    );
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      entry_valid_q <= '0;
      for (int unsigned i = 0; i < MaxTxns; i++) data_q[i] <= '0;
    end else begin
      count_q <= count_next;
      // Push and pop never target the same slot: pop needs a non-empty
      // buffer and push needs a non-full one.
      if (pop) begin
        entry_valid_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q                <= ptr_inc(rd_ptr_q);
      end
      if (push) begin
        entry_valid_q[wr_ptr_q] <= 1'b1;
        data_q[wr_ptr_q]        <= wr_entry.data;
        wr_ptr_q                <= ptr_inc(wr_ptr_q);
      end
    end
  end

`ifdef FLOO_LATENCY_MODEL_STATS_EN
  logic [31:0]         stat_beats_q, stat_stall_q;
  logic [CntWidth-1:0] stat_max_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stat_beats_q <= '0;
      stat_stall_q <= '0;
      stat_max_q   <= '0;
    end else begin
      if (push) stat_beats_q <= stat_beats_q + 32'd1;
      if (valid_o && !ready_i && (stat_stall_q != '1)) stat_stall_q <= stat_stall_q + 32'd1;
      if (count_next > stat_max_q) stat_max_q <= count_next;
    end
  end

  assign stat_beats_o        = stat_beats_q;
  assign stat_max_pending_o  = stat_max_q;
  assign stat_stall_cycles_o = stat_stall_q;
`endif

endmodule
